linear_regression: RTL and testbench

// - Ordinary least-squares fit of y = b0 + b1*x over a batch of N signed fixed-point samples.
// - Loads N (x,y) pairs after a start request, computes b1 and b0, then streams the N residuals y - (b0 + b1*x).
// - Standalone datapath and FSM.
// - Samples are held in internal storage between the load and error phases.

---
 rtl/linear_regression.sv | 217 +++++++++++++++++++++
 tb/tb_linear_regression.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/linear_regression.sv
// Batch ordinary-least-squares line fit y = b0 + b1*x over N signed Q-format
// samples, followed by a residual stream in load order.
module linear_regression #(
  parameter int unsigned N    = 150,
  parameter int unsigned W    = 20,
  parameter int unsigned FRAC = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         start,
  output logic [W-1:0] b0,
  output logic [W-1:0] b1,
  output logic [W-1:0] err,
  output logic         ready,
  output logic         errDone
);

  localparam int unsigned SW  = W + 8;       // sample sums
  localparam int unsigned DW  = W + 1;       // deviation from the mean
  localparam int unsigned ACW = 2 * W + 8;   // covariance accumulators
  localparam int unsigned QW  = ACW + FRAC;  // divider numerator / quotient
  localparam int unsigned RW  = ACW + 1;     // shifted divider remainder
  localparam int unsigned EW  = 2 * W + 2;   // pre-saturation results
  localparam int unsigned CW  = $clog2(N + 1);

  localparam logic signed [EW-1:0] SAT_MAX = $signed({{(EW-W+1){1'b0}}, {(W-1){1'b1}}});
  localparam logic signed [EW-1:0] SAT_MIN = $signed({{(EW-W+1){1'b1}}, {(W-1){1'b0}}});

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MEAN, S_COV, S_DIV, S_B0, S_ERR
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]          mem_x [N];
  logic [W-1:0]          mem_y [N];
  logic [CW-1:0]         cnt_q;
  logic                  ph_q;
  logic signed [SW-1:0]  sum_x_q, sum_y_q;
  logic signed [W-1:0]   mx_q, my_q;
  logic signed [ACW-1:0] sxy_q, sxx_q;
  logic [QW-1:0]         num_q, q_q;
  logic [ACW-1:0]        den_q, rem_q;
  logic                  neg_q, sxx_zero_q;
  logic [W-1:0]          b0_q, b1_q, err_q;
  logic                  ready_q, errdone_q;

  logic                  last_n_c;
  logic [W-1:0]          xi_c, yi_c;
  logic signed [DW-1:0]  dx_c, dy_c;
  logic signed [2*DW-1:0] pxy_c, pxx_c;
  logic [ACW-1:0]        abs_xy_c;
  logic [RW-1:0]         rem_sh_c;
  logic                  ge_c;
  logic [W:0]            qm_c;
  logic signed [EW-1:0]  qv_c, b0w_c, ew_c;
  logic signed [2*W-1:0] pb0_c, pe_c;
  logic [W-1:0]          b1_c, b0_c, err_c;

  function automatic logic [W-1:0] sat_w(input logic signed [EW-1:0] v);
    logic [W-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[W-1:0];
    else                  r = v[W-1:0];
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign last_n_c = (cnt_q == CW'(N - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  if (ph_q && last_n_c) state_d = S_MEAN;
      S_MEAN:  state_d = S_COV;
      S_COV:   if (last_n_c) state_d = S_DIV;
      S_DIV:   if (cnt_q == CW'(QW)) state_d = S_B0;
      S_B0:    state_d = S_ERR;
      S_ERR:   if (last_n_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: deviations, divider step, b0/b1 and residual arithmetic
  always_comb begin
    xi_c     = mem_x[cnt_q];
    yi_c     = mem_y[cnt_q];
    dx_c     = DW'($signed(xi_c)) - DW'(mx_q);
    dy_c     = DW'($signed(yi_c)) - DW'(my_q);
    pxy_c    = dx_c * dy_c;
    pxx_c    = dx_c * dx_c;
    abs_xy_c = sxy_q[ACW-1] ? ACW'(-sxy_q) : ACW'(sxy_q);
    rem_sh_c = {rem_q, num_q[QW-1]};
    ge_c     = (rem_sh_c >= {1'b0, den_q});
    // Any quotient bit at or above 2^W already means saturation
    qm_c     = (|q_q[QW-1:W]) ? {1'b1, W'(0)} : {1'b0, q_q[W-1:0]};
    qv_c     = $signed(EW'(qm_c));
    if (neg_q) qv_c = -qv_c;
    b1_c     = sxx_zero_q ? W'(0) : sat_w(qv_c);
    pb0_c    = $signed(b1_c) * mx_q;
    b0w_c    = EW'(my_q) - EW'(pb0_c >>> FRAC);
    b0_c     = sat_w(b0w_c);
    pe_c     = $signed(b1_q) * $signed(xi_c);
    ew_c     = EW'($signed(yi_c)) - (EW'($signed(b0_q)) + EW'(pe_c >>> FRAC));
    err_c    = sat_w(ew_c);
  end

  // Sample storage, written on capture edges only
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && ph_q) begin
      mem_x[cnt_q] <= x;
      mem_y[cnt_q] <= y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      ph_q       <= 1'b0;
      sum_x_q    <= '0;
      sum_y_q    <= '0;
      mx_q       <= '0;
      my_q       <= '0;
      sxy_q      <= '0;
      sxx_q      <= '0;
      num_q      <= '0;
      q_q        <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      neg_q      <= 1'b0;
      sxx_zero_q <= 1'b0;
      b0_q       <= '0;
      b1_q       <= '0;
      err_q      <= '0;
      ready_q    <= 1'b0;
      errdone_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          ready_q   <= start;
          errdone_q <= 1'b0;
          cnt_q     <= '0;
          ph_q      <= 1'b0;
          sum_x_q   <= '0;
          sum_y_q   <= '0;
        end
        S_LOAD: begin
          // Each pair is held two cycles; capture on the second one
          ph_q <= ~ph_q;
          if (ph_q) begin
            sum_x_q <= sum_x_q + SW'($signed(x));
            sum_y_q <= sum_y_q + SW'($signed(y));
            cnt_q   <= cnt_q + CW'(1);
            if (last_n_c) begin
              ready_q <= 1'b0;
              cnt_q   <= '0;
            end
          end
        end
        S_MEAN: begin
          mx_q  <= W'(sum_x_q / $signed(SW'(N)));
          my_q  <= W'(sum_y_q / $signed(SW'(N)));
          sxy_q <= '0;
          sxx_q <= '0;
          cnt_q <= '0;
        end
        S_COV: begin
          sxy_q <= sxy_q + ACW'(pxy_c);
          sxx_q <= sxx_q + ACW'(pxx_c);
          cnt_q <= last_n_c ? '0 : cnt_q + CW'(1);
        end
        S_DIV: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == '0) begin
            num_q      <= {abs_xy_c, {FRAC{1'b0}}};
            den_q      <= $unsigned(sxx_q);
            neg_q      <= sxy_q[ACW-1];
            sxx_zero_q <= (sxx_q == '0);
            rem_q      <= '0;
            q_q        <= '0;
          end else begin
            num_q <= num_q << 1;
            q_q   <= {q_q[QW-2:0], ge_c};
            rem_q <= ge_c ? ACW'(rem_sh_c - {1'b0, den_q}) : rem_sh_c[ACW-1:0];
          end
        end
        S_B0: begin
          b1_q  <= b1_c;
          b0_q  <= b0_c;
          cnt_q <= '0;
        end
        S_ERR: begin
          err_q     <= err_c;
          errdone_q <= 1'b1;
          cnt_q     <= cnt_q + CW'(1);
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign b0      = b0_q;
  assign b1      = b1_q;
  assign err     = err_q;
  assign ready   = ready_q;
  assign errDone = errdone_q;

endmodule

// File: tb/tb_linear_regression.sv
// Directed bench for linear_regression: table of sample patterns with
// hand-computed fit results, plus start-hold and mid-batch reset sequences.
module tb_linear_regression;

  localparam int unsigned N    = 150;
  localparam int unsigned W    = 20;
  localparam int unsigned FRAC = 10;
  localparam int LAT_MAX = 4 * N + 3 * W + 16;

  logic         clk = 1'b0;
  logic         rst, start, ready, errDone;
  logic [W-1:0] x, y, b0, b1, err;

  int checks   = 0;
  int failures = 0;

  // Sample k: x = xa[k%2] + xs*k, y = ya[k%2] + ys*k; residuals alternate ee0/ee1
  typedef struct {
    int xa0; int xa1; int xs;
    int ya0; int ya1; int ys;
    int eb0; int eb1; int ee0; int ee1;
  } vec_t;

  vec_t vecs [6];

  linear_regression #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clk     (clk),
    .rst     (rst),
    .x       (x),
    .y       (y),
    .start   (start),
    .b0      (b0),
    .b1      (b1),
    .err     (err),
    .ready   (ready),
    .errDone (errDone)
  );

  always #5 clk = ~clk;

  task automatic check(input string what, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", what, act, exp);
    end
  endtask

  function automatic logic [W-1:0] smp(input int a0, input int a1, input int s, input int k);
    int v;
    v = (((k % 2) == 0) ? a0 : a1) + s * k;
    return W'(v);
  endfunction

  // Called at a negedge: reset for one edge, then every output must read 0
  task automatic reset_check(input string tag);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    check({tag, " b0"}, b0, '0);
    check({tag, " b1"}, b1, '0);
    check({tag, " err"}, err, '0);
    check({tag, " ready"}, W'(ready), '0);
    check({tag, " errDone"}, W'(errDone), '0);
    rst = 1'b0;
  endtask

  task automatic run_batch(input vec_t v, input int id, input bit hold,
                           input int abort_load, input int abort_err);
    int n;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (!ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d ready rise", id), W'(ready), W'(1));
    if (!ready) begin
      start = 1'b0;
      return;
    end
    if (!hold) start = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (k == abort_load) begin
        reset_check($sformatf("v%0d rst@load", id));
        return;
      end
      x = smp(v.xa0, v.xa1, v.xs, k);
      y = smp(v.ya0, v.ya1, v.ys, k);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
    end
    check($sformatf("v%0d ready after load", id), W'(ready), '0);
    n = 0;
    while (!errDone && n < LAT_MAX) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d errDone within latency", id), W'(errDone), W'(1));
    if (!errDone) return;
    for (int i = 0; i < int'(N); i++) begin
      if (i == abort_err) begin
        reset_check($sformatf("v%0d rst@err", id));
        return;
      end
      check($sformatf("v%0d errDone[%0d]", id, i), W'(errDone), W'(1));
      check($sformatf("v%0d err[%0d]", id, i), err, W'(((i % 2) == 0) ? v.ee0 : v.ee1));
      if (hold && i == 0) start = 1'b0;
      @(negedge clk);
    end
    check($sformatf("v%0d errDone fall", id), W'(errDone), '0);
    check($sformatf("v%0d b0", id), b0, W'(v.eb0));
    check($sformatf("v%0d b1", id), b1, W'(v.eb1));
    check($sformatf("v%0d idle ready", id), W'(ready), '0);
  endtask

  initial begin
    // y = 2x + 1, x = -74..75
    vecs[0] = '{-75776, -75776, 1024, -150528, -150528, 2048, 1024, 2048, 0, 0};
    // y = -x + 3
    vecs[1] = '{-75776, -75776, 1024, 78848, 78848, -1024, 3072, -1024, 0, 0};
    // all x = 1.0, y alternating 1.0 / 3.0
    vecs[2] = '{1024, 1024, 0, 1024, 3072, 0, 2048, 0, -1024, 1024};
    // slope too steep: b1 saturates positive
    vecs[3] = '{0, 2, 0, -102400, 102400, 0, -511, 524287, -101889, 101888};
    // x ~ +510, y ~ -510, slope 1.5: b0 and err saturate negative
    vecs[4] = '{521216, 523264, 0, -523776, -520704, 0, -524288, 1536, -524288, -524288};
    // x ~ -510, y ~ +510, slope 1.5: b0 and err saturate positive
    vecs[5] = '{-521216, -523264, 0, 523776, 520704, 0, 524287, 1536, 524287, 524287};

    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset b0", b0, '0);
    check("reset b1", b1, '0);
    check("reset err", err, '0);
    check("reset ready", W'(ready), '0);
    check("reset errDone", W'(errDone), '0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) run_batch(vecs[v], v, 1'b0, -1, -1);

    // Reset during LOAD, then a clean batch
    run_batch(vecs[0], 10, 1'b0, 10, -1);
    run_batch(vecs[0], 11, 1'b0, -1, -1);

    // start held through LOAD and compute: exactly one batch, then a repeat
    run_batch(vecs[2], 12, 1'b1, -1, -1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("no second batch c%0d", c), W'(ready), '0);
    end
    run_batch(vecs[2], 13, 1'b0, -1, -1);

    // Reset during ERR, then a clean batch
    run_batch(vecs[4], 14, 1'b0, -1, 20);
    run_batch(vecs[1], 15, 1'b0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
